// File: rtl/xor_crypt_mem_responder_if.sv
// Bus bundle between the core-side message pins, the XOR responder and one
// main_memory port.
//   req_*      : core -> responder request (msg 0 none, 1 read, 2 write)
//   req_ready  : responder -> core, high while the responder can accept
//   resp_*     : responder -> core response (1 ack, 2 read data, 3 error)
//   mem_*_out  : responder -> memory request (1 read, 2 write)
//   mem_*_in   : memory -> responder response (1 write ack, 2 read data)
// Modports: slave = responder view, master = core/memory environment view.
interface xor_crypt_mem_responder_if #(
    parameter int ADDRESS_BITS = 12
);
    logic [2:0]              req_msg;
    logic [ADDRESS_BITS:0]   req_address;
    logic [31:0]             req_data;
    logic                    req_ready;
    logic [2:0]              resp_msg;
    logic [ADDRESS_BITS:0]   resp_address;
    logic [31:0]             resp_data;
    logic [2:0]              mem_msg_out;
    logic [ADDRESS_BITS:0]   mem_address_out;
    logic [31:0]             mem_data_out;
    logic [2:0]              mem_msg_in;
    logic [ADDRESS_BITS:0]   mem_address_in;
    logic [31:0]             mem_data_in;

    modport slave (
        input  req_msg, req_address, req_data,
        input  mem_msg_in, mem_address_in, mem_data_in,
        output req_ready, resp_msg, resp_address, resp_data,
        output mem_msg_out, mem_address_out, mem_data_out
    );

    modport master (
        output req_msg, req_address, req_data,
        output mem_msg_in, mem_address_in, mem_data_in,
        input  req_ready, resp_msg, resp_address, resp_data,
        input  mem_msg_out, mem_address_out, mem_data_out
    );
endinterface

// File: rtl/xor_crypt_mem_responder.sv
// Memory-side responder: accepts one core request at a time, forwards it to
// main memory and returns the response. Addresses with the region bit
// (bit ADDRESS_BITS) clear are stored XOR-encrypted with a keystream derived
// from the captured key and the word address; region bit set is plaintext.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   key   : cipher key, sampled when a request is captured
//   bus   : request/response/memory bundle (slave modport)
module xor_crypt_mem_responder #(
    parameter int ADDRESS_BITS = 12,
    parameter int TIMEOUT      = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [31:0]                 key,
    xor_crypt_mem_responder_if.slave    bus
);
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [2:0] REQ_RD   = 3'd1;
    localparam logic [2:0] REQ_WR   = 3'd2;
    localparam logic [2:0] MEM_ACK  = 3'd1;
    localparam logic [2:0] MEM_DATA = 3'd2;
    localparam logic [2:0] RSP_ACK  = 3'd1;
    localparam logic [2:0] RSP_DATA = 3'd2;
    localparam logic [2:0] RSP_ERR  = 3'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [2:0]            msg_q, msg_d;
    logic [ADDRESS_BITS:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [31:0]           key_q, key_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            rmsg_q, rmsg_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  match;

    function automatic logic [31:0] ks(input logic [ADDRESS_BITS-1:0] a,
                                       input logic [31:0] k);
        logic [31:0] a32;
        a32 = 32'(a);
        return k ^ (a32 << 16) ^ a32;
    endfunction

    // Same transform both ways; the region bit bypasses it.
    function automatic logic [31:0] xcrypt(input logic [31:0] d,
                                           input logic [ADDRESS_BITS:0] a,
                                           input logic [31:0] k);
        return a[ADDRESS_BITS] ? d : (d ^ ks(a[ADDRESS_BITS-1:0], k));
    endfunction

    // Response type must correspond to the outstanding request type.
    assign match = (bus.mem_address_in == addr_q) &&
                   (((msg_q == REQ_RD) && (bus.mem_msg_in == MEM_DATA)) ||
                    ((msg_q == REQ_WR) && (bus.mem_msg_in == MEM_ACK)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            msg_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            rmsg_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            rmsg_q  <= rmsg_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        addr_d  = addr_q;
        data_d  = data_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        rmsg_d  = rmsg_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if ((bus.req_msg == REQ_RD) || (bus.req_msg == REQ_WR)) begin
                    msg_d   = bus.req_msg;
                    addr_d  = bus.req_address;
                    data_d  = bus.req_data;
                    key_d   = key;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A match on the timeout cycle takes priority over the error.
                if (match) begin
                    rmsg_d  = (msg_q == REQ_RD) ? RSP_DATA : RSP_ACK;
                    rdata_d = (msg_q == REQ_RD) ? xcrypt(bus.mem_data_in, addr_q, key_q) : '0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rmsg_d  = RSP_ERR;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready       = (state_q == IDLE);
        bus.mem_msg_out     = '0;
        bus.mem_address_out = '0;
        bus.mem_data_out    = '0;
        bus.resp_msg        = '0;
        bus.resp_address    = '0;
        bus.resp_data       = '0;
        if (state_q == ISSUE) begin
            bus.mem_msg_out     = msg_q;
            bus.mem_address_out = addr_q;
            bus.mem_data_out    = (msg_q == REQ_WR) ? xcrypt(data_q, addr_q, key_q) : '0;
        end
        if (state_q == RESP) begin
            bus.resp_msg     = rmsg_q;
            bus.resp_address = addr_q;
            bus.resp_data    = rdata_q;
        end
    end
endmodule

// File: tb/tb_xor_crypt_mem_responder.sv
module tb_xor_crypt_mem_responder;
    localparam int AB = 12;
    localparam int TO = 64;

    typedef struct {
        logic [2:0]  msg;
        logic [AB:0] addr;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [2:0]  msg;
        logic [AB:0] addr;
        logic [31:0] data;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] key;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    bit          mem_bad_addr = 1'b0;
    resp_t       resp_q[$];
    mreq_t       mreq_q[$];
    logic [31:0] mem[logic [AB:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    xor_crypt_mem_responder_if #(.ADDRESS_BITS(AB)) bus();

    xor_crypt_mem_responder #(.ADDRESS_BITS(AB), .TIMEOUT(TO)) dut (
        .clock(clk),
        .reset(rst),
        .key  (key),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: answers each request after mem_lat edges, optionally
    // with a corrupted address.
    initial begin
        logic [2:0]  m;
        logic [AB:0] a;
        logic [31:0] d;
        bus.mem_msg_in     = '0;
        bus.mem_address_in = '0;
        bus.mem_data_in    = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_msg_out != 3'd0) begin
                m = bus.mem_msg_out;
                a = bus.mem_address_out;
                d = bus.mem_data_out;
                if (m == 3'd2) mem[a] = d;
                repeat (mem_lat) @(posedge clk);
                #1;
                bus.mem_msg_in     = (m == 3'd1) ? 3'd2 : 3'd1;
                bus.mem_address_in = mem_bad_addr ? a + 1'b1 : a;
                bus.mem_data_in    = ((m == 3'd1) && mem.exists(a)) ? mem[a] : 32'h0;
                @(posedge clk);
                #1;
                bus.mem_msg_in     = '0;
                bus.mem_address_in = '0;
                bus.mem_data_in    = '0;
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (bus.resp_msg != 3'd0) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", {29'd0, bus.resp_msg}, 32'd0);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_msg", {29'd0, bus.resp_msg}, {29'd0, e.msg});
                    check("resp_address", {19'd0, bus.resp_address}, {19'd0, e.addr});
                    check("resp_data", bus.resp_data, e.data);
                    check("resp_latency", cyc, e.cyc);
                end
            end
        end
    end

    // Memory-request monitor.
    initial begin
        mreq_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_msg_out != 3'd0) begin
                if (mreq_q.size() == 0) begin
                    check("unexpected_mem_req", {29'd0, bus.mem_msg_out}, 32'd0);
                end else begin
                    e = mreq_q.pop_front();
                    check("mem_msg_out", {29'd0, bus.mem_msg_out}, {29'd0, e.msg});
                    check("mem_address_out", {19'd0, bus.mem_address_out}, {19'd0, e.addr});
                    if (e.msg == 3'd2) check("mem_data_out", bus.mem_data_out, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [2:0] m, input logic [AB:0] a, input logic [31:0] d,
                        input logic [31:0] k, output int cap);
        int n = 0;
        @(negedge clk);
        bus.req_msg     = m;
        bus.req_address = a;
        bus.req_data    = d;
        key             = k;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check("req_ready_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cap         = cyc;
        bus.req_msg = 3'd0;
    endtask

    task automatic txn(input logic [2:0] m, input logic [AB:0] a, input logic [31:0] d,
                       input logic [31:0] k, input logic [31:0] mdata,
                       input logic [2:0] rmsg, input logic [31:0] rdata,
                       input int total, output int cap);
        send(m, a, d, k, cap);
        mreq_q.push_back('{msg: m, addr: a, data: mdata});
        resp_q.push_back('{msg: rmsg, addr: a, data: rdata, cyc: cap + total - 1});
    endtask

    task automatic drain();
        int n = 0;
        while ((resp_q.size() != 0 || mreq_q.size() != 0 || !bus.req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        check({tag, "_resp_msg"}, {29'd0, bus.resp_msg}, 32'd0);
        check({tag, "_resp_address"}, {19'd0, bus.resp_address}, 32'd0);
        check({tag, "_resp_data"}, bus.resp_data, 32'd0);
        check({tag, "_mem_msg_out"}, {29'd0, bus.mem_msg_out}, 32'd0);
        check({tag, "_mem_address_out"}, {19'd0, bus.mem_address_out}, 32'd0);
        check({tag, "_mem_data_out"}, bus.mem_data_out, 32'd0);
    endtask

    initial begin
        int c1, c2;
        rst             = 1'b1;
        key             = '0;
        bus.req_msg     = '0;
        bus.req_address = '0;
        bus.req_data    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;

        // Plain region write then read-back.
        mem_lat = 1;
        txn(3'd2, 13'h1010, 32'h12345678, 32'hA5A5A5A5, 32'h12345678, 3'd1, 32'h0, 3, c1);
        drain();
        txn(3'd1, 13'h1010, 32'h0, 32'hA5A5A5A5, 32'h0, 3'd2, 32'h12345678, 3, c1);
        drain();

        // Encrypted region: ks = 0xA5B5A5B5.
        txn(3'd2, 13'h0010, 32'h00000013, 32'hA5A5A5A5, 32'hA5B5A5A6, 3'd1, 32'h0, 3, c1);
        drain();
        txn(3'd1, 13'h0010, 32'h0, 32'hA5A5A5A5, 32'h0, 3'd2, 32'h00000013, 3, c1);
        drain();

        // 3-cycle memory; second request held through the busy period.
        // ks(0x0ABC, 0x01234567) = 0x0B9F4FDB.
        mem_lat = 3;
        txn(3'd2, 13'h0ABC, 32'hDEADBEEF, 32'h01234567, 32'hD532F134, 3'd1, 32'h0, 5, c1);
        txn(3'd1, 13'h0ABC, 32'h0, 32'h01234567, 32'h0, 3'd2, 32'hDEADBEEF, 5, c2);
        check("held_req_capture", c2, c1 + 6);
        drain();

        // Wrong-address reply only: error after TIMEOUT+2 cycles.
        mem_lat      = 1;
        mem_bad_addr = 1'b1;
        txn(3'd1, 13'h0010, 32'h0, 32'hA5A5A5A5, 32'h0, 3'd3, 32'h0, TO + 2, c1);
        drain();
        mem_bad_addr = 1'b0;
        txn(3'd1, 13'h0010, 32'h0, 32'hA5A5A5A5, 32'h0, 3'd2, 32'h00000013, 3, c1);
        drain();

        // Key changed right after capture must not affect decryption.
        txn(3'd1, 13'h0010, 32'h0, 32'hA5A5A5A5, 32'h0, 3'd2, 32'h00000013, 3, c1);
        key = 32'h0;
        drain();

        // Reset during WAIT; memory reply lands after reset is released.
        mem_lat = 6;
        send(3'd1, 13'h1010, 32'h0, 32'hA5A5A5A5, c1);
        mreq_q.push_back('{msg: 3'd1, addr: 13'h1010, data: 32'h0});
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("post_reset");
        repeat (4) @(negedge clk);
        mem_lat = 1;
        drain();

        if (resp_q.size() != 0) check("resp_queue_leftover", resp_q.size(), 32'd0);
        if (mreq_q.size() != 0) check("mreq_queue_leftover", mreq_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
